// File: rtl/pht_update_scheduler.sv
// Table of 2-bit saturating branch counters behind one shared port.
// Predict lookups have priority. Updates queue in a FIFO and drain through a read-modify-write FSM.
module pht_update_scheduler #(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      pred_valid,
    input  logic [IDX_W-1:0]          pred_idx,
    output logic                      pred_ready,
    output logic                      pred_resp_valid,
    output logic                      pred_taken,
    input  logic                      upd_valid,
    input  logic [IDX_W-1:0]          upd_idx,
    input  logic                      upd_outcome,
    output logic                      upd_ready,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ST_W    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_t;

    state_t             state, next_state;
    logic [1:0]         pht [ENTRIES];
    logic [IDX_W-1:0]   fifo_idx [QDEPTH];
    logic               fifo_out [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [ST_W-1:0]    starve;
    logic [IDX_W-1:0]   hold_idx;
    logic               hold_out;
    logic [1:0]         hold_ctr;
    logic               force_c, push, pop, pred_fire;

    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign force_c    = (q_count == CNT_W'(QDEPTH)) ||
                        ((starve >= ST_W'(STARVE_MAX)) && (q_count != '0));
    assign pred_ready = (state == IDLE) && !force_c;
    assign upd_ready  = (q_count != CNT_W'(QDEPTH));
    assign busy       = (state != IDLE) || (q_count != '0);
    assign push       = upd_valid && upd_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Port arbitration: forced drain, then predict, then opportunistic drain
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        pred_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (force_c) begin
                    pop = 1'b1;
                end else if (pred_valid) begin
                    pred_fire = 1'b1;
                end else if (q_count != '0) begin
                    pop = 1'b1;
                end
                if (pop) next_state = UPD_RD;
            end
            UPD_RD:  next_state = UPD_WR;
            UPD_WR:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
        end else if (state == UPD_WR) begin
            pht[hold_idx] <= sat_next(hold_ctr, hold_out);
        end
    end

    // FIFO payload storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_idx[wr_ptr] <= upd_idx;
            fifo_out[wr_ptr] <= upd_outcome;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            q_count         <= '0;
            starve          <= '0;
            hold_idx        <= '0;
            hold_out        <= 1'b0;
            hold_ctr        <= 2'b00;
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                hold_idx <= fifo_idx[rd_ptr];
                hold_out <= fifo_out[rd_ptr];
            end
            if (push && !pop)      q_count <= q_count + CNT_W'(1);
            else if (pop && !push) q_count <= q_count - CNT_W'(1);

            if (q_count == '0 || pop)                           starve <= '0;
            else if (state == IDLE && starve < ST_W'(STARVE_MAX)) starve <= starve + ST_W'(1);

            if (state == UPD_RD) hold_ctr <= pht[hold_idx];

            pred_resp_valid <= pred_fire;
            if (pred_fire) pred_taken <= pht[pred_idx][1];
        end
    end
endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed plus random bench for pht_update_scheduler.
// The reference model is a counter array, an update queue and a busy countdown.
module tb_pht_update_scheduler;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned ENTRIES    = 1 << IDX_W;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             pred_valid = 1'b0;
    logic [IDX_W-1:0] pred_idx = '0;
    logic             pred_ready, pred_resp_valid, pred_taken;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_outcome = 1'b0;
    logic             upd_ready, busy;
    logic [2:0]       q_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ctr [ENTRIES];
    int m_qi [$];
    int m_qo [$];
    int m_starve, m_phase, m_hold_i, m_hold_o;
    bit m_resp_v, m_resp_t;

    // DUT values seen at the last sample point
    logic       seen_ready, seen_upd_ready;
    logic [2:0] seen_q;

    pht_update_scheduler #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_ready(pred_ready),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_outcome(upd_outcome),
        .upd_ready(upd_ready), .q_count(q_count), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_qi.delete();
        m_qo.delete();
        m_starve = 0;
        m_phase  = 0;
        m_resp_v = 0;
        m_resp_t = 0;
    endfunction

    // m_phase counts the port cycles an update still needs: 2 = read pending, 1 = write pending
    task automatic cycle(input logic pv, input logic [IDX_W-1:0] pi,
                         input logic uv, input logic [IDX_W-1:0] ui, input logic uo);
        int n;
        bit frc, idle, serve, start;
        @(negedge clock);
        pred_valid = pv; pred_idx = pi;
        upd_valid = uv; upd_idx = ui; upd_outcome = uo;
        #1;
        n     = m_qi.size();
        frc   = (n == QDEPTH) || (m_starve >= STARVE_MAX && n != 0);
        idle  = (m_phase == 0);
        serve = idle && !frc && pv;
        start = idle && !serve && n != 0;

        seen_ready = pred_ready; seen_upd_ready = upd_ready; seen_q = q_count;
        check("pred_ready", 32'(pred_ready), 32'(idle && !frc));
        check("upd_ready", 32'(upd_ready), 32'(n != QDEPTH));
        check("q_count", 32'(q_count), 32'(n));
        check("busy", 32'(busy), 32'(!idle || n != 0));
        check("pred_resp_valid", 32'(pred_resp_valid), 32'(m_resp_v));
        if (m_resp_v) check("pred_taken", 32'(pred_taken), 32'(m_resp_t));

        m_resp_v = serve;
        if (serve) m_resp_t = (m_ctr[pi] >= 2);
        if (m_phase == 1) begin
            if (m_hold_o != 0) m_ctr[m_hold_i] = (m_ctr[m_hold_i] < 3) ? m_ctr[m_hold_i] + 1 : 3;
            else               m_ctr[m_hold_i] = (m_ctr[m_hold_i] > 0) ? m_ctr[m_hold_i] - 1 : 0;
        end
        if (n == 0 || start)               m_starve = 0;
        else if (idle)                     m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        if (start) begin
            m_hold_i = m_qi.pop_front();
            m_hold_o = m_qo.pop_front();
        end
        if (uv && n != QDEPTH) begin
            m_qi.push_back(int'(ui));
            m_qo.push_back(int'(uo));
        end
        m_phase = start ? 2 : (m_phase > 0 ? m_phase - 1 : 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // One predict with a constant expected outcome, checked right after the response edge
    task automatic predict_const(input string tag, input logic [IDX_W-1:0] idx, input logic exp_t);
        cycle(1'b1, idx, 1'b0, '0, 1'b0);
        check({tag, "_ready"}, 32'(seen_ready), 32'(1));
        @(posedge clock); #1;
        check({tag, "_valid"}, 32'(pred_resp_valid), 32'(1));
        check({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
    endtask

    initial begin
        int served;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("rst_resp_valid", 32'(pred_resp_valid), 32'(0));
        check("rst_pred_taken", 32'(pred_taken), 32'(0));
        check("rst_upd_ready", 32'(upd_ready), 32'(1));
        check("rst_q_count", 32'(q_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset_n = 1'b1;

        predict_const("t1_idx3", 4'd3, 1'b0);

        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 4'd5, 1'b1);
        idle_cycles(8);
        predict_const("t2_idx5", 4'd5, 1'b1);

        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 4'd2, 1'b0);
        idle_cycles(6);
        predict_const("t3_idx2", 4'd2, 1'b0);
        cycle(1'b0, '0, 1'b1, 4'd2, 1'b1);
        idle_cycles(4);
        predict_const("t3_sat", 4'd2, 1'b0);

        // Starvation guard: one queued update under continuous predicts
        cycle(1'b1, 4'd0, 1'b1, 4'd7, 1'b1);
        served = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 4'd0, 1'b0, '0, 1'b0);
            if (seen_ready) served++;
        end
        check("starve_served", 32'(served), 32'(STARVE_MAX));
        cycle(1'b1, 4'd0, 1'b0, '0, 1'b0);
        check("starve_resume", 32'(seen_ready), 32'(1));
        idle_cycles(2);

        // Fill to full with predicts held high
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'd1, 1'b1, IDX_W'(8 + i), 1'b1);
        cycle(1'b1, 4'd1, 1'b1, 4'd12, 1'b1);
        check("full_upd_ready", 32'(seen_upd_ready), 32'(0));
        check("full_pred_ready", 32'(seen_ready), 32'(0));
        check("full_q", 32'(seen_q), 32'(4));
        cycle(1'b1, 4'd1, 1'b1, 4'd12, 1'b1);
        check("pop_q", 32'(seen_q), 32'(3));
        check("pop_upd_ready", 32'(seen_upd_ready), 32'(1));
        idle_cycles(20);

        // Reset while an update is in its write cycle with two more queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd0, 1'b1, 4'd5, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(pred_resp_valid), 32'(0));
        check("mid_rst_pred_taken", 32'(pred_taken), 32'(0));
        check("mid_rst_upd_ready", 32'(upd_ready), 32'(1));
        check("mid_rst_q_count", 32'(q_count), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < int'(ENTRIES); i++) predict_const("rst_tbl", IDX_W'(i), 1'b0);
        cycle(1'b0, '0, 1'b1, 4'd5, 1'b0);
        idle_cycles(4);
        predict_const("rst_tbl5", 4'd5, 1'b0);
        cycle(1'b0, '0, 1'b1, 4'd6, 1'b1);
        idle_cycles(4);
        predict_const("rst_tbl6", 4'd6, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), IDX_W'($urandom),
                  ($urandom_range(0, 2) == 0), IDX_W'($urandom_range(0, 5)), 1'($urandom));
        end
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Owns a table of 2^IDX_W two-bit saturating branch counters behind one shared access port.
- Schedules two requesters onto that port: predict lookups from fetch, and resolved-outcome updates from retire.
- Updates are buffered in a small FIFO and drained by a read-modify-write FSM.
- Predicts take priority, with a starvation guard and a full-queue override so updates always drain.

Parameters:
- IDX_W, 4, table index width; the table has 2^IDX_W entries.
- QDEPTH, 4, update FIFO depth; power of 2, at least 2.
- STARVE_MAX, 8, number of consecutive non-empty-queue cycles without an update start before updates are forced.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pred_valid  in  1  predict lookup request.
- pred_idx  in  IDX_W  predict table index.
- pred_ready  out  1  lookup accepted this cycle when pred_valid is also high.
- pred_resp_valid  out  1  pulses 1 cycle after an accepted lookup.
- pred_taken  out  1  MSB of the looked-up counter; valid when pred_resp_valid is high.
- upd_valid  in  1  update request.
- upd_idx  in  IDX_W  counter index to update.
- upd_outcome  in  1  1 = taken (increment), 0 = not-taken (decrement).
- upd_ready  out  1  FIFO not full.
- q_count  out  clog2(QDEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all counters = 2'b01 (weakly not-taken);
  - FIFO empty; FSM = IDLE; starve counter = 0;
  - pred_resp_valid = 0, pred_taken = 0, upd_ready = 1, q_count = 0, busy = 0.
  - Reset mid-RMW drops the in-flight update and all queued updates. No partial writes.
- Counter rule:
  - taken: 00→01→10→11, saturates at 11;
  - not-taken: 11→10→01→00, saturates at 00;
  - prediction = bit[1].
- FIFO:
  - enqueue on upd_valid && upd_ready; upd_ready = (q_count != QDEPTH);
  - dequeue (head captured into a holding register) on the IDLE→UPD_RD transition;
  - enqueue and dequeue in the same cycle leave q_count unchanged;
  - pointers wrap modulo QDEPTH.
- force = (q_count == QDEPTH) || (starve >= STARVE_MAX && q_count != 0).
- pred_ready = (state == IDLE) && !force. This is combinational; pred_ready does not depend on pred_valid.
- FSM:
  - IDLE, force=1: go to UPD_RD and pop the head; no predict is served.
  - IDLE, force=0, pred_valid=1: serve the predict (port read); stay in IDLE. Next cycle pred_resp_valid=1 and pred_taken = table[pred_idx][1], sampled at acceptance.
  - IDLE, force=0, pred_valid=0, q_count!=0: go to UPD_RD and pop the head.
  - UPD_RD: read table[hold_idx] into a hold register; go to UPD_WR.
  - UPD_WR: write the saturated next value; go to IDLE.
  - Port use: UPD_RD and UPD_WR each occupy the port, so an update costs 2 cycles with pred_ready=0. Each cycle has at most one table access.
- Starve counter:
  - increments each IDLE cycle with q_count != 0 that does not start an update;
  - clears on IDLE→UPD_RD, and whenever q_count == 0;
  - saturates at STARVE_MAX.
- Ordering:
  - updates apply in FIFO order;
  - a predict accepted after the UPD_WR cycle sees the written value;
  - a predict accepted while the same index is still queued sees the pre-update value (no forwarding).
- pred_resp_valid is 0 in every cycle not following an accepted lookup.

Test Plan:
- Reset, then predict idx 3 → pred_ready=1; next cycle pred_resp_valid=1, pred_taken=0 (counter 01).
- Update idx 5 taken ×3 with no predicts → counter goes 01→10→11→11. Each update spans 2 busy cycles. A subsequent predict idx 5 gives pred_taken=1.
- Update idx 2 not-taken ×2 from reset → counter goes 01→00→00 (saturates). A predict idx 2 gives pred_taken=0.
- Continuous pred_valid while 1 update is queued, STARVE_MAX=8 → 8 predicts served, then pred_ready=0 for 2 cycles while the update drains. starve resets to 0.
- Fill the FIFO with 4 updates while pred_valid is held high → upd_ready=0 at q_count=4 and force takes effect immediately. A 5th upd_valid is not accepted until the first pop; q_count then reads 3 and upd_ready=1.
- Assert reset_n=0 during UPD_WR with 2 updates queued → outputs return to reset values in the same cycle. The table reads 01 at every index, and q_count=0.
